// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises/debounces areset_n, then releases per-channel resets in order.
// Optional build macro RESET_SEQ_ORDERED_ASSERT_EN: soft reset re-asserts channels in descending order.
`timescale 1ns/1ps
module reset_sequencer #(
   parameter int unsigned CHANNELS      = 2,
   parameter int unsigned SYNC_STAGES   = 4,
   parameter int unsigned DEBOUNCE_BITS = 8,
   parameter int unsigned STAGE_DELAY   = 16
) (
   input  logic                clock,
   input  logic                areset_n,
   input  logic                soft_req,
   output logic [CHANNELS-1:0] reset,
   output logic                ready
);

   localparam int unsigned SW = $clog2(STAGE_DELAY + 1);
   localparam int unsigned IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_DELAY - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(CHANNELS - 1);

   typedef enum logic [1:0] {
      HOLD,
      RELEASE,
`ifdef RESET_SEQ_ORDERED_ASSERT_EN
      DRAIN,
`endif
      RUN
   } state_t;

   logic [SYNC_STAGES-1:0]   sync_q;
   logic                     int_rst;
   state_t                   state_q, state_d;
   logic [DEBOUNCE_BITS-1:0] deb_q, deb_d;
   logic [SW-1:0]            cnt_q, cnt_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [CHANNELS-1:0]      reset_q, reset_d;
   logic                     ready_q, ready_d;

   always_ff @(posedge clock or negedge areset_n) begin
      if (!areset_n) sync_q <= '1;
      else           sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
   end

   assign int_rst = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock or negedge areset_n) begin
      if (!areset_n) begin
         state_q <= HOLD;
         deb_q   <= '1;
         cnt_q   <= '0;
         idx_q   <= '0;
         reset_q <= '1;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         reset_q <= reset_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      reset_d = reset_q;
      ready_d = ready_q;
      case (state_q)
         HOLD: begin
            if (!int_rst) begin
               if (deb_q == '0) begin
                  reset_d[0] = 1'b0;
                  cnt_d      = '0;
                  if (CHANNELS == 1) begin
                     ready_d = 1'b1;
                     state_d = RUN;
                  end else begin
                     idx_d   = IW'(1);
                     state_d = RELEASE;
                  end
               end else begin
                  deb_d = deb_q - DEBOUNCE_BITS'(1);
               end
            end
         end
         RELEASE: begin
            if (cnt_q == STAGE_LAST) begin
               cnt_d = '0;
               for (int unsigned i = 0; i < CHANNELS; i++)
                  if (idx_q == IW'(i)) reset_d[i] = 1'b0;
               if (idx_q == IDX_LAST) begin
                  ready_d = 1'b1;
                  state_d = RUN;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               cnt_d = cnt_q + SW'(1);
            end
         end
         RUN: begin
            if (soft_req) begin
               ready_d = 1'b0;
`ifdef RESET_SEQ_ORDERED_ASSERT_EN
               // Highest channel goes first; DRAIN walks the index back down to 0.
               if (CHANNELS == 1) begin
                  reset_d = '1;
                  deb_d   = '1;
                  state_d = HOLD;
               end else begin
                  reset_d[CHANNELS-1] = 1'b1;
                  cnt_d   = '0;
                  idx_d   = IW'((CHANNELS > 1) ? CHANNELS - 2 : 0);
                  state_d = DRAIN;
               end
`else
               reset_d = '1;
               deb_d   = '1;
               state_d = HOLD;
`endif
            end
         end
`ifdef RESET_SEQ_ORDERED_ASSERT_EN
         DRAIN: begin
            if (cnt_q == STAGE_LAST) begin
               cnt_d = '0;
               for (int unsigned i = 0; i < CHANNELS; i++)
                  if (idx_q == IW'(i)) reset_d[i] = 1'b1;
               if (idx_q == '0) begin
                  deb_d   = '1;
                  state_d = HOLD;
               end else begin
                  idx_d = idx_q - IW'(1);
               end
            end else begin
               cnt_d = cnt_q + SW'(1);
            end
         end
`endif
         default: state_d = HOLD;
      endcase
   end

   assign reset = reset_q;
   assign ready = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default configuration plus a 4-channel fast configuration.
`timescale 1ns/1ps
module tb_reset_sequencer;

   logic       clock = 1'b0;
   logic       areset_n, soft_req;
   logic [1:0] reset;
   logic       ready;
   logic       areset4_n, soft4;
   logic [3:0] reset4;
   logic       ready4;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;
   int unsigned e       = 0;
   int unsigned ev      = 0;

`ifdef RESET_SEQ_ORDERED_ASSERT_EN
   localparam int unsigned LOOP4   = 9;
   localparam logic [3:0]  RST4_E8 = 4'b1000;
`else
   localparam int unsigned LOOP4   = 6;
   localparam logic [3:0]  RST4_E8 = 4'b1111;
`endif

   always #5 clock = ~clock;

   reset_sequencer #(
      .CHANNELS(2), .SYNC_STAGES(4), .DEBOUNCE_BITS(8), .STAGE_DELAY(16)
   ) dut (
      .clock(clock), .areset_n(areset_n), .soft_req(soft_req), .reset(reset), .ready(ready)
   );

   reset_sequencer #(
      .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_BITS(1), .STAGE_DELAY(1)
   ) dut4 (
      .clock(clock), .areset_n(areset4_n), .soft_req(soft4), .reset(reset4), .ready(ready4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      e++;
   endtask

   task automatic step_to(input int unsigned target);
      while (e < target) step();
   endtask

   // Edge 1 is the first rising edge after the release.
   task automatic release_main();
      @(negedge clock);
      areset_n = 1'b1;
      e = 0;
   endtask

   task automatic check_seq(input string tag);
      step_to(259); check({tag, "_259_rst"}, reset, 2'b11); check({tag, "_259_rdy"}, ready, 0);
      step_to(260); check({tag, "_260_rst"}, reset, 2'b10); check({tag, "_260_rdy"}, ready, 0);
      step_to(275); check({tag, "_275_rst"}, reset, 2'b10); check({tag, "_275_rdy"}, ready, 0);
      step_to(276); check({tag, "_276_rst"}, reset, 2'b00); check({tag, "_276_rdy"}, ready, 1);
   endtask

   initial begin
      areset_n  = 1'b0;
      soft_req  = 1'b0;
      areset4_n = 1'b0;
      soft4     = 1'b1;
      repeat (10) @(posedge clock);
      #1;
      check("por_rst", reset, 2'b11);
      check("por_rdy", ready, 0);
      check("por_rst4", reset4, 4'hF);
      check("por_rdy4", ready4, 0);

      release_main();
      check_seq("por");

      // Sub-cycle areset_n pulse in RUN
      step_to(280);
      #1 areset_n = 1'b0;
      #1;
      check("pulse_async_rst", reset, 2'b11);
      check("pulse_async_rdy", ready, 0);
      #2 areset_n = 1'b1;
      e = 0;
      check_seq("pulse");

      // One-cycle soft reset request in RUN
      step_to(300);
      soft_req = 1'b1;
      step();
      soft_req = 1'b0;
      ev = e;
`ifdef RESET_SEQ_ORDERED_ASSERT_EN
      check("soft_E_rst", reset, 2'b10);     check("soft_E_rdy", ready, 0);
      step_to(ev + 15);  check("soft_E15_rst", reset, 2'b10);
      step_to(ev + 16);  check("soft_E16_rst", reset, 2'b11);
      step_to(ev + 271); check("soft_E271_rst", reset, 2'b11);
      step_to(ev + 272); check("soft_E272_rst", reset, 2'b10);
      step_to(ev + 287); check("soft_E287_rst", reset, 2'b10); check("soft_E287_rdy", ready, 0);
      step_to(ev + 288); check("soft_E288_rst", reset, 2'b00); check("soft_E288_rdy", ready, 1);
`else
      check("soft_E_rst", reset, 2'b11);     check("soft_E_rdy", ready, 0);
      step_to(ev + 255); check("soft_E255_rst", reset, 2'b11);
      step_to(ev + 256); check("soft_E256_rst", reset, 2'b10);
      step_to(ev + 271); check("soft_E271_rst", reset, 2'b10); check("soft_E271_rdy", ready, 0);
      step_to(ev + 272); check("soft_E272_rst", reset, 2'b00); check("soft_E272_rdy", ready, 1);
`endif

      // areset_n asserted mid-RELEASE at edge 268
      step_to(e + 10);
      areset_n = 1'b0;
      step();
      step();
      release_main();
      step_to(267); check("mid_267_rst", reset, 2'b10);
      step();       check("mid_268_rst", reset, 2'b10);
      #1 areset_n = 1'b0;
      #1;
      check("mid_async_rst", reset, 2'b11);
      check("mid_async_rdy", ready, 0);
      step();
      check("mid_held_rst", reset, 2'b11);
      release_main();
      check_seq("mid");

      // 4-channel fast configuration with soft_req held high
      @(negedge clock);
      areset4_n = 1'b1;
      e = 0;
      step_to(3); check("c4_e3_rst", reset4, 4'b1111); check("c4_e3_rdy", ready4, 0);
      step_to(4); check("c4_e4_rst", reset4, 4'b1110);
      step_to(5); check("c4_e5_rst", reset4, 4'b1100);
      step_to(6); check("c4_e6_rst", reset4, 4'b1000); check("c4_e6_rdy", ready4, 0);
      step_to(7); check("c4_e7_rst", reset4, 4'b0000); check("c4_e7_rdy", ready4, 1);
      step_to(8); check("c4_e8_rst", reset4, RST4_E8);
      for (int unsigned k = 8; k <= 30; k++) begin
         step_to(k);
         check("c4_loop_rdy", ready4, ((k - 7) % LOOP4) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
